sargantana_icache_fill_mshr: RTL and testbench

//  Parametrised miss-status holding register file for the Sargantana I$: tracks up to NUM_ENTRIES outstanding

---
 rtl/sargantana_icache_fill_mshr.sv | 163 ++++++++++++++++
 tb/tb_sargantana_icache_fill_mshr.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sargantana_icache_fill_mshr.sv
// Miss-status holding registers for Sargantana I$ line fills: merges same-line misses, issues
// fill requests, assembles multi-beat responses by id and poisons fills hit by inv/flush.
module sargantana_icache_fill_mshr #(
  parameter int NUM_ENTRIES = 4,
  parameter int PADDR_SIZE  = 40,
  parameter int LINE_OFF    = 6,
  parameter int BEAT_W      = 128,
  parameter int BEATS       = 4,
  parameter int ID_W        = $clog2(NUM_ENTRIES),
  parameter int LINE_W      = BEAT_W * BEATS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  miss_valid_i,
  input  logic [PADDR_SIZE-1:0] miss_paddr_i,
  output logic                  miss_ready_o,
  output logic                  fill_req_valid_o,
  input  logic                  fill_req_ready_i,
  output logic [PADDR_SIZE-1:0] fill_req_paddr_o,
  output logic [ID_W-1:0]       fill_req_id_o,
  input  logic                  fill_resp_valid_i,
  input  logic [ID_W-1:0]       fill_resp_id_i,
  input  logic [BEAT_W-1:0]     fill_resp_data_i,
  input  logic                  inv_valid_i,
  input  logic [PADDR_SIZE-1:0] inv_paddr_i,
  output logic                  refill_valid_o,
  output logic [PADDR_SIZE-1:0] refill_paddr_o,
  output logic [LINE_W-1:0]     refill_data_o,
  output logic                  busy_o,
  output logic                  miss_pmu_o
);
  localparam int TAG_W = PADDR_SIZE - LINE_OFF;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {ST_FREE, ST_PEND, ST_WAIT, ST_FILL, ST_DONE} state_e;

  state_e                 r_state  [NUM_ENTRIES];
  logic [TAG_W-1:0]       r_tag    [NUM_ENTRIES];
  logic [CNT_W-1:0]       r_beat   [NUM_ENTRIES];
  logic [LINE_W-1:0]      r_data   [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] r_poison;
  logic                   r_reqValid;
  logic [ID_W-1:0]        r_reqId;

  logic [TAG_W-1:0]       w_missTag, w_invTag;
  logic [NUM_ENTRIES-1:0] w_free, w_live, w_match, w_done, w_invHit, w_pendNext;
  logic [ID_W-1:0]        w_allocIdx, w_refillIdx, w_pendIdx;
  logic                   w_missReady, w_missFire, w_alloc, w_reqFire, w_refillValid;
  logic                   w_unused;

  assign w_missTag = miss_paddr_i[PADDR_SIZE-1:LINE_OFF];
  assign w_invTag  = inv_paddr_i[PADDR_SIZE-1:LINE_OFF];
  assign w_unused  = ^{miss_paddr_i[LINE_OFF-1:0], inv_paddr_i[LINE_OFF-1:0]};

  // A miss that coincides with an invalidation of its own line must not merge into the dying entry.
  always_comb begin
    w_free   = '0;
    w_live   = '0;
    w_match  = '0;
    w_done   = '0;
    w_invHit = '0;
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      w_free[e]   = (r_state[e] == ST_FREE);
      w_live[e]   = (r_state[e] != ST_FREE) && !r_poison[e];
      w_match[e]  = w_live[e] && (r_tag[e] == w_missTag) && !(inv_valid_i && (w_invTag == w_missTag));
      w_done[e]   = (r_state[e] == ST_DONE) && !r_poison[e];
      w_invHit[e] = inv_valid_i && (r_state[e] != ST_FREE) && (r_tag[e] == w_invTag);
    end
  end

  assign w_missReady   = !flush_i && ((|w_free) || (|w_match));
  assign w_missFire    = miss_valid_i && w_missReady;
  assign w_alloc       = w_missFire && !(|w_match);
  assign w_reqFire     = r_reqValid && fill_req_ready_i;
  assign w_refillValid = |w_done;

  // Pending set after this edge, so a freshly allocated entry can be presented the very next cycle.
  always_comb begin
    w_pendNext  = '0;
    w_allocIdx  = '0;
    w_refillIdx = '0;
    w_pendIdx   = '0;
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      w_pendNext[e] = (r_state[e] == ST_PEND)
                    && !(w_reqFire && (r_reqId == ID_W'(e)))
                    && !(flush_i && !(r_reqValid && (r_reqId == ID_W'(e))));
    end
    for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
      if (w_free[e]) w_allocIdx = ID_W'(e);
      if (w_done[e]) w_refillIdx = ID_W'(e);
    end
    if (w_alloc) w_pendNext[w_allocIdx] = 1'b1;
    for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
      if (w_pendNext[e]) w_pendIdx = ID_W'(e);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        r_state[e] <= ST_FREE;
        r_tag[e]   <= '0;
        r_beat[e]  <= '0;
      end
      r_poison   <= '0;
      r_reqValid <= 1'b0;
      r_reqId    <= '0;
    end else begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        case (r_state[e])
          ST_FREE: begin
            if (w_alloc && (w_allocIdx == ID_W'(e))) begin
              r_state[e]  <= ST_PEND;
              r_tag[e]    <= w_missTag;
              r_beat[e]   <= '0;
              r_poison[e] <= 1'b0;
            end
          end
          ST_PEND: begin
            if (w_invHit[e] || flush_i) r_poison[e] <= 1'b1;
            if (w_reqFire && (r_reqId == ID_W'(e))) r_state[e] <= ST_WAIT;
            else if (flush_i && !(r_reqValid && (r_reqId == ID_W'(e)))) r_state[e] <= ST_FREE;
          end
          ST_WAIT, ST_FILL: begin
            if (w_invHit[e] || flush_i) r_poison[e] <= 1'b1;
            if (fill_resp_valid_i && (fill_resp_id_i == ID_W'(e))) begin
              r_data[e][r_beat[e]*BEAT_W +: BEAT_W] <= fill_resp_data_i;
              if (r_beat[e] == CNT_W'(BEATS - 1)) begin
                r_beat[e]  <= '0;
                r_state[e] <= (r_poison[e] || w_invHit[e] || flush_i) ? ST_FREE : ST_DONE;
              end else begin
                r_beat[e]  <= r_beat[e] + CNT_W'(1);
                r_state[e] <= ST_FILL;
              end
            end
          end
          ST_DONE: begin
            if (w_invHit[e] || flush_i) r_poison[e] <= 1'b1;
            if (r_poison[e] || (w_refillValid && (w_refillIdx == ID_W'(e)))) r_state[e] <= ST_FREE;
          end
          default: r_state[e] <= ST_FREE;
        endcase
      end
      // The presented request is frozen until the upper level takes it.
      if (!r_reqValid || fill_req_ready_i) begin
        r_reqValid <= |w_pendNext;
        r_reqId    <= w_pendIdx;
      end
    end
  end

  assign miss_ready_o     = w_missReady;
  assign fill_req_valid_o = r_reqValid;
  assign fill_req_id_o    = r_reqId;
  assign fill_req_paddr_o = r_reqValid ? {r_tag[r_reqId], {LINE_OFF{1'b0}}} : '0;
  assign refill_valid_o   = w_refillValid;
  assign refill_paddr_o   = w_refillValid ? {r_tag[w_refillIdx], {LINE_OFF{1'b0}}} : '0;
  assign refill_data_o    = w_refillValid ? r_data[w_refillIdx] : '0;
  assign busy_o           = !(&w_free);
  assign miss_pmu_o       = |w_live;

endmodule

// File: tb/tb_sargantana_icache_fill_mshr.sv
// Self-checking bench for sargantana_icache_fill_mshr: scenario tasks with randomized
// addresses/beat data checked against a line-level model of expected fills and refills.
module tb_sargantana_icache_fill_mshr;
  localparam int NE  = 4;
  localparam int PA  = 40;
  localparam int LO  = 6;
  localparam int BW  = 128;
  localparam int NB  = 4;
  localparam int IDW = 2;
  localparam int LW  = BW * NB;

  logic           clk_i = 1'b0;
  logic           rst_i, flush_i, miss_valid_i, fill_req_ready_i, fill_resp_valid_i, inv_valid_i;
  logic [PA-1:0]  miss_paddr_i, inv_paddr_i;
  logic [IDW-1:0] fill_resp_id_i;
  logic [BW-1:0]  fill_resp_data_i;
  logic           miss_ready_o, fill_req_valid_o, refill_valid_o, busy_o, miss_pmu_o;
  logic [PA-1:0]  fill_req_paddr_o, refill_paddr_o;
  logic [IDW-1:0] fill_req_id_o;
  logic [LW-1:0]  refill_data_o;

  int checks = 0;
  int failures = 0;

  // Observed handshakes/refills and the model's expected refills, in order.
  logic [IDW-1:0] reqIdQ[$];
  logic [PA-1:0]  reqAddrQ[$];
  logic [PA-1:0]  refAddrQ[$];
  logic [LW-1:0]  refDataQ[$];
  logic [PA-1:0]  expAddrQ[$];
  logic [LW-1:0]  expDataQ[$];

  logic           mdlActive [NE];
  logic           mdlPoison [NE];
  int             mdlBeats  [NE];
  logic [PA-1:0]  mdlAddr   [NE];
  logic [LW-1:0]  mdlLine   [NE];

  sargantana_icache_fill_mshr dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .miss_valid_i(miss_valid_i), .miss_paddr_i(miss_paddr_i), .miss_ready_o(miss_ready_o),
    .fill_req_valid_o(fill_req_valid_o), .fill_req_ready_i(fill_req_ready_i),
    .fill_req_paddr_o(fill_req_paddr_o), .fill_req_id_o(fill_req_id_o),
    .fill_resp_valid_i(fill_resp_valid_i), .fill_resp_id_i(fill_resp_id_i),
    .fill_resp_data_i(fill_resp_data_i),
    .inv_valid_i(inv_valid_i), .inv_paddr_i(inv_paddr_i),
    .refill_valid_o(refill_valid_o), .refill_paddr_o(refill_paddr_o),
    .refill_data_o(refill_data_o), .busy_o(busy_o), .miss_pmu_o(miss_pmu_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [PA-1:0] lineOf(input logic [PA-1:0] a);
    return (a >> LO) << LO;
  endfunction

  function automatic logic [PA-1:0] randAddr(input int uniq);
    logic [PA-1:0] p;
    p = PA'({$urandom, $urandom});
    p[LO+1:LO] = 2'(uniq);
    return p;
  endfunction

  // Samples the current cycle, then advances to just after the next rising edge.
  task automatic cycle();
    #1;
    if (fill_req_valid_o && fill_req_ready_i) begin
      reqIdQ.push_back(fill_req_id_o);
      reqAddrQ.push_back(fill_req_paddr_o);
    end
    if (refill_valid_o) begin
      refAddrQ.push_back(refill_paddr_o);
      refDataQ.push_back(refill_data_o);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic doReset();
    rst_i = 1'b1; flush_i = 1'b0; miss_valid_i = 1'b0; miss_paddr_i = '0;
    fill_req_ready_i = 1'b0; fill_resp_valid_i = 1'b0; fill_resp_id_i = '0;
    fill_resp_data_i = '0; inv_valid_i = 1'b0; inv_paddr_i = '0;
    cycle();
    cycle();
    rst_i = 1'b0;
    reqIdQ.delete(); reqAddrQ.delete(); refAddrQ.delete(); refDataQ.delete();
    expAddrQ.delete(); expDataQ.delete();
    for (int i = 0; i < NE; i++) begin
      mdlActive[i] = 1'b0; mdlPoison[i] = 1'b0; mdlBeats[i] = 0; mdlAddr[i] = '0; mdlLine[i] = '0;
    end
  endtask

  task automatic allocModel(input int id, input logic [PA-1:0] a);
    mdlActive[id] = 1'b1; mdlPoison[id] = 1'b0; mdlBeats[id] = 0; mdlAddr[id] = lineOf(a);
  endtask

  task automatic sendMiss(input logic [PA-1:0] a);
    miss_valid_i = 1'b1; miss_paddr_i = a;
    cycle();
    miss_valid_i = 1'b0;
  endtask

  task automatic sendBeat(input int id);
    logic [BW-1:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    fill_resp_valid_i = 1'b1; fill_resp_id_i = IDW'(id); fill_resp_data_i = d;
    if (mdlActive[id]) begin
      mdlLine[id][mdlBeats[id]*BW +: BW] = d;
      mdlBeats[id]++;
      if (mdlBeats[id] == NB) begin
        if (!mdlPoison[id]) begin
          expAddrQ.push_back(mdlAddr[id]);
          expDataQ.push_back(mdlLine[id]);
        end
        mdlActive[id] = 1'b0;
        mdlBeats[id] = 0;
      end
    end
    cycle();
    fill_resp_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    #1;
    checks++; if (miss_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_miss_ready: got %b want 1", miss_ready_o); end
    checks++; if (fill_req_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_fill_req_valid: got %b want 0", fill_req_valid_o); end
    checks++; if (refill_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_refill_valid: got %b want 0", refill_valid_o); end
    checks++; if ({busy_o, miss_pmu_o} !== 2'b00) begin failures++; $display("[TB] FAIL reset_busy_pmu: got %b want 00", {busy_o, miss_pmu_o}); end
  endtask

  task automatic test_basic_fill();
    logic [PA-1:0] a;
    doReset();
    a = 40'h00_8000_0040;
    miss_valid_i = 1'b1; miss_paddr_i = a;
    #1;
    checks++; if (miss_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL basic_miss_ready: got %b want 1", miss_ready_o); end
    cycle();
    miss_valid_i = 1'b0;
    allocModel(0, a);
    #1;
    checks++; if ({fill_req_valid_o, fill_req_paddr_o, fill_req_id_o} !== {1'b1, lineOf(a), 2'd0})
      begin failures++; $display("[TB] FAIL basic_fill_req: got v=%b a=%h id=%0d want v=1 a=%h id=0", fill_req_valid_o, fill_req_paddr_o, fill_req_id_o, lineOf(a)); end
    fill_req_ready_i = 1'b1;
    cycle();
    fill_req_ready_i = 1'b0;
    checks++; if (fill_req_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL basic_req_drop: got %b want 0", fill_req_valid_o); end
    for (int k = 0; k < NB; k++) sendBeat(0);
    #1;
    checks++; if ({refill_valid_o, refill_paddr_o} !== {1'b1, expAddrQ[0]})
      begin failures++; $display("[TB] FAIL basic_refill: got v=%b a=%h want v=1 a=%h", refill_valid_o, refill_paddr_o, expAddrQ[0]); end
    checks++; if (refill_data_o !== expDataQ[0]) begin failures++; $display("[TB] FAIL basic_refill_data: got %h want %h", refill_data_o, expDataQ[0]); end
    cycle();
    checks++; if ({refill_valid_o, busy_o} !== 2'b00) begin failures++; $display("[TB] FAIL basic_after_refill: got %b want 00", {refill_valid_o, busy_o}); end
  endtask

  task automatic test_merge_and_capacity();
    doReset();
    fill_req_ready_i = 1'b1;
    sendMiss(40'h1000);
    allocModel(0, 40'h1000);
    miss_valid_i = 1'b1; miss_paddr_i = 40'h1008;
    #1;
    checks++; if (miss_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL merge_ready: got %b want 1", miss_ready_o); end
    cycle();
    miss_valid_i = 1'b0;
    repeat (3) cycle();
    checks++; if ((reqIdQ.size() !== 1) || (reqAddrQ[0] !== 40'h1000) || (reqIdQ[0] !== 2'd0))
      begin failures++; $display("[TB] FAIL merge_single_req: got n=%0d want n=1 a=0x1000 id=0", reqIdQ.size()); end
    for (int k = 0; k < NB; k++) sendBeat(0);
    repeat (2) cycle();
    checks++; if ((refAddrQ.size() !== 1) || (refAddrQ[0] !== 40'h1000) || (refDataQ[0] !== expDataQ[0]))
      begin failures++; $display("[TB] FAIL merge_refill: got n=%0d want n=1 a=0x1000", refAddrQ.size()); end
    doReset();
    for (int i = 0; i <= NE; i++) begin
      miss_valid_i = 1'b1; miss_paddr_i = randAddr(i);
      #1;
      checks++; if (miss_ready_o !== (i < NE))
        begin failures++; $display("[TB] FAIL capacity_ready_%0d: got %b want %b", i, miss_ready_o, (i < NE)); end
      cycle();
    end
    miss_valid_i = 1'b0;
  endtask

  task automatic test_interleave();
    logic [PA-1:0] a, b;
    doReset();
    a = randAddr(0); b = randAddr(1);
    fill_req_ready_i = 1'b1;
    sendMiss(a); allocModel(0, a);
    sendMiss(b); allocModel(1, b);
    repeat (2) cycle();
    fill_req_ready_i = 1'b0;
    checks++; if ((reqIdQ.size() !== 2) || ({reqIdQ[0], reqAddrQ[0], reqIdQ[1], reqAddrQ[1]} !== {2'd0, lineOf(a), 2'd1, lineOf(b)}))
      begin failures++; $display("[TB] FAIL interleave_reqs: got n=%0d want ids 0,1 a=%h b=%h", reqIdQ.size(), lineOf(a), lineOf(b)); end
    for (int k = 0; k < NB; k++) begin sendBeat(1); sendBeat(0); end
    repeat (3) cycle();
    checks++; if (refAddrQ.size() !== expAddrQ.size())
      begin failures++; $display("[TB] FAIL interleave_count: got %0d want %0d", refAddrQ.size(), expAddrQ.size()); end
    for (int i = 0; i < refAddrQ.size() && i < expAddrQ.size(); i++) begin
      checks++; if ({refAddrQ[i], refDataQ[i]} !== {expAddrQ[i], expDataQ[i]})
        begin failures++; $display("[TB] FAIL interleave_refill_%0d: got a=%h want a=%h", i, refAddrQ[i], expAddrQ[i]); end
    end
  endtask

  task automatic test_invalidate();
    doReset();
    fill_req_ready_i = 1'b1;
    sendMiss(40'h2000); allocModel(0, 40'h2000);
    cycle();
    fill_req_ready_i = 1'b0;
    sendBeat(0);
    inv_valid_i = 1'b1; inv_paddr_i = 40'h2010;
    mdlPoison[0] = 1'b1;
    cycle();
    inv_valid_i = 1'b0;
    #1;
    checks++; if ({busy_o, miss_pmu_o} !== 2'b10) begin failures++; $display("[TB] FAIL inv_poisoned: got busy,pmu=%b want 10", {busy_o, miss_pmu_o}); end
    for (int k = 1; k < NB; k++) sendBeat(0);
    repeat (2) cycle();
    checks++; if (refAddrQ.size() !== 0) begin failures++; $display("[TB] FAIL inv_no_refill: got %0d refills want 0", refAddrQ.size()); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL inv_free: got busy %b want 0", busy_o); end
  endtask

  task automatic test_flush_and_stale();
    logic [PA-1:0] a, b, c;
    doReset();
    a = randAddr(0); b = randAddr(1); c = randAddr(2);
    fill_req_ready_i = 1'b1;
    sendMiss(a); allocModel(0, a);
    cycle();
    fill_req_ready_i = 1'b0;
    sendMiss(b); allocModel(1, b);
    sendMiss(c); allocModel(2, c);
    flush_i = 1'b1; miss_valid_i = 1'b1; miss_paddr_i = randAddr(3);
    #1;
    checks++; if (miss_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL flush_miss_ready: got %b want 0", miss_ready_o); end
    cycle();
    flush_i = 1'b0; miss_valid_i = 1'b0;
    mdlPoison[0] = 1'b1; mdlPoison[1] = 1'b1; mdlActive[2] = 1'b0;
    #1;
    checks++; if ({miss_pmu_o, busy_o} !== 2'b01) begin failures++; $display("[TB] FAIL flush_pmu_busy: got pmu,busy=%b want 01", {miss_pmu_o, busy_o}); end
    checks++; if ({fill_req_valid_o, fill_req_id_o, fill_req_paddr_o} !== {1'b1, 2'd1, lineOf(b)})
      begin failures++; $display("[TB] FAIL flush_held_req: got v=%b id=%0d a=%h want v=1 id=1 a=%h", fill_req_valid_o, fill_req_id_o, fill_req_paddr_o, lineOf(b)); end
    fill_req_ready_i = 1'b1;
    cycle();
    fill_req_ready_i = 1'b0;
    checks++; if (fill_req_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL flush_pend_freed: got req valid %b want 0", fill_req_valid_o); end
    for (int k = 0; k < NB; k++) begin sendBeat(0); sendBeat(1); end
    repeat (2) cycle();
    checks++; if ({refAddrQ.size() == 0, busy_o} !== 2'b10)
      begin failures++; $display("[TB] FAIL flush_drain: got refills=%0d busy=%b want 0,0", refAddrQ.size(), busy_o); end
    fill_req_ready_i = 1'b1;
    sendMiss(a);
    cycle();
    doReset();
    for (int k = 0; k < NB; k++) sendBeat(0);
    repeat (2) cycle();
    checks++; if ({refAddrQ.size() == 0, busy_o} !== 2'b10)
      begin failures++; $display("[TB] FAIL stale_after_reset: got refills=%0d busy=%b want 0,0", refAddrQ.size(), busy_o); end
  endtask

  task automatic test_stall();
    logic [PA-1:0] a, b;
    doReset();
    a = randAddr(0); b = randAddr(1);
    sendMiss(a);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin miss_valid_i = 1'b1; miss_paddr_i = b; end
      #1;
      checks++; if ({fill_req_valid_o, fill_req_paddr_o, fill_req_id_o} !== {1'b1, lineOf(a), 2'd0})
        begin failures++; $display("[TB] FAIL stall_hold_%0d: got v=%b a=%h id=%0d want v=1 a=%h id=0", i, fill_req_valid_o, fill_req_paddr_o, fill_req_id_o, lineOf(a)); end
      cycle();
      miss_valid_i = 1'b0;
    end
    fill_req_ready_i = 1'b1;
    cycle();
    fill_req_ready_i = 1'b0;
    #1;
    checks++; if ({fill_req_valid_o, fill_req_paddr_o, fill_req_id_o} !== {1'b1, lineOf(b), 2'd1})
      begin failures++; $display("[TB] FAIL stall_next: got v=%b a=%h id=%0d want v=1 a=%h id=1", fill_req_valid_o, fill_req_paddr_o, fill_req_id_o, lineOf(b)); end
  endtask

  task automatic test_back_to_back();
    for (int round = 0; round < 4; round++) begin
      int n, left, guard;
      int rem [NE];
      logic [PA-1:0] a;
      doReset();
      n = $urandom_range(1, NE);
      fill_req_ready_i = 1'b1;
      for (int i = 0; i < n; i++) begin
        a = randAddr(i);
        sendMiss(a); allocModel(i, a);
        rem[i] = NB;
      end
      repeat (2) cycle();
      fill_req_ready_i = 1'b0;
      checks++; if (reqIdQ.size() !== n) begin failures++; $display("[TB] FAIL b2b_req_count_%0d: got %0d want %0d", round, reqIdQ.size(), n); end
      for (int i = 0; i < n && i < reqIdQ.size(); i++) begin
        checks++; if ({reqIdQ[i], reqAddrQ[i]} !== {2'(i), mdlAddr[i]})
          begin failures++; $display("[TB] FAIL b2b_req_%0d_%0d: got id=%0d a=%h want id=%0d a=%h", round, i, reqIdQ[i], reqAddrQ[i], i, mdlAddr[i]); end
      end
      left = n * NB;
      guard = 0;
      while (left > 0 && guard < 200) begin
        int id;
        id = $urandom_range(0, n - 1);
        if (rem[id] > 0) begin sendBeat(id); rem[id]--; left--; end
        else cycle();
        guard++;
      end
      repeat (3) cycle();
      checks++; if ((left != 0) || (refAddrQ.size() !== expAddrQ.size()))
        begin failures++; $display("[TB] FAIL b2b_refill_count_%0d: got %0d want %0d (beats left %0d)", round, refAddrQ.size(), expAddrQ.size(), left); end
      for (int i = 0; i < refAddrQ.size() && i < expAddrQ.size(); i++) begin
        checks++; if ({refAddrQ[i], refDataQ[i]} !== {expAddrQ[i], expDataQ[i]})
          begin failures++; $display("[TB] FAIL b2b_refill_%0d_%0d: got a=%h want a=%h", round, i, refAddrQ[i], expAddrQ[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_merge_and_capacity();
    test_interleave();
    test_invalidate();
    test_flush_and_stale();
    test_stall();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
